// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the sram_param block.
//   - default parameter constants (data width, depth, read latency)
//   - controller state type: INIT (clear sweep running) and READY
package sram_pkg;

  localparam int SRAM_DATA_W_DEF = 32;
  localparam int SRAM_DEPTH_DEF  = 16;
  localparam int SRAM_RD_LAT_DEF = 1;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } sram_state_t;

endpackage

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: RD_LAT-deep delay line for read results.
//   clk, rst          : clock, synchronous active-high flush
//   i_vld/i_dat/i_perr: read accepted this edge, array word, parity mismatch
//   o_vld/o_dat/o_perr: rvalid pulse, rdata (held between pulses), perr pulse
// Each data stage only loads when its valid is set, so the final stage keeps
// the last returned word while no read is emerging.
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W_DEF,
  parameter int RD_LAT = SRAM_RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_dat,
  input  logic              i_perr,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_dat,
  output logic              o_perr
);

  if (RD_LAT < 1 || RD_LAT > 2) begin : g_lat_chk
    $error("sram_rd_pipe: RD_LAT must be 1 or 2");
  end

  logic [RD_LAT-1:0] r_vld_p;
  logic [RD_LAT-1:0] r_perr_p;
  logic [DATA_W-1:0] r_dat_p [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p  <= '0;
      r_perr_p <= '0;
      for (int i = 0; i < RD_LAT; i++) r_dat_p[i] <= '0;
    end else begin
      // stage 0: capture the word read at the request edge
      r_vld_p[0]  <= i_vld;
      r_perr_p[0] <= i_vld & i_perr;
      if (i_vld) r_dat_p[0] <= i_dat;
      // stages 1..RD_LAT-1: plain shift, data moves only with its valid
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_p[i]  <= r_vld_p[i-1];
        r_perr_p[i] <= r_perr_p[i-1];
        if (r_vld_p[i-1]) r_dat_p[i] <= r_dat_p[i-1];
      end
    end
  end

  assign o_vld  = r_vld_p[RD_LAT-1];
  assign o_perr = r_perr_p[RD_LAT-1];
  assign o_dat  = r_dat_p[RD_LAT-1];

endmodule

// File: rtl/sram_param.sv
// sram_param: single-port byte-writable SRAM with a post-reset clear sweep.
//   clk, rst : clock, synchronous active-high reset
//   wr, rd   : write / read request (both together is rejected)
//   addr     : word address, addr >= DEPTH is rejected
//   wdata    : write data, wstrb: per-byte write enables
//   rdata    : read data, qualified by rvalid (RD_LAT cycles after request)
//   busy     : clear sweep in progress, all requests rejected
//   err      : one-cycle pulse, request rejected
//   perr     : one-cycle pulse with rvalid, stored parity mismatch
// Optional feature macro SRAM_PARAM_PARITY_EN: stores one even-parity bit per
// byte and checks it on read; without it perr is constant 0.
module sram_param
  import sram_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W_DEF,
  parameter int DEPTH  = SRAM_DEPTH_DEF,
  parameter int RD_LAT = SRAM_RD_LAT_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic                rd,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                busy,
  output logic                err,
  output logic                perr
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  sram_state_t       r_state;
  logic [IDX_W-1:0]  r_sweep;
  logic              r_busy;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_addr_ok;
  logic              w_ready;
  logic              w_wr_fire;
  logic              w_rd_fire;
  logic              w_req_bad;
  logic              w_sweep_we;
  logic              w_perr_raw;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rd_dat;

  // Address may be wider than the array index (e.g. to expose out-of-range
  // requests), so range-check in ADDR_W+1 bits and index with the low bits.
  assign w_addr_ok  = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));
  assign w_idx      = addr[IDX_W-1:0];
  assign w_ready    = (r_state == READY) && !rst;
  assign w_wr_fire  = w_ready && wr && !rd && w_addr_ok;
  assign w_rd_fire  = w_ready && rd && !wr && w_addr_ok;
  assign w_req_bad  = (wr || rd) && ((wr && rd) || !w_addr_ok);
  assign w_sweep_we = (r_state == INIT) && !rst;
  assign w_rd_dat   = r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_sweep <= '0;
      r_busy  <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_err <= wr || rd;
          if (r_sweep == LAST_IDX) begin
            r_state <= READY;
            r_busy  <= 1'b0;
          end else begin
            r_sweep <= r_sweep + 1'b1;
          end
        end
        READY: r_err <= w_req_bad;
      endcase
    end
  end

  // Array has no reset; it is cleared only by the sweep after each reset.
  always_ff @(posedge clk) begin
    if (w_sweep_we) begin
      r_mem[r_sweep] <= '0;
    end else if (w_wr_fire) begin
      for (int b = 0; b < NB; b++)
        if (wstrb[b]) r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

`ifdef SRAM_PARAM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];

  function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] d);
    logic [NB-1:0] p;
    for (int b = 0; b < NB; b++) p[b] = ^d[8*b +: 8];
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (w_sweep_we) begin
      r_par[r_sweep] <= '0;
    end else if (w_wr_fire) begin
      for (int b = 0; b < NB; b++)
        if (wstrb[b]) r_par[w_idx][b] <= ^wdata[8*b +: 8];
    end
  end

  assign w_perr_raw = |(r_par[w_idx] ^ byte_par(w_rd_dat));
`else
  assign w_perr_raw = 1'b0;
`endif

  sram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (w_rd_fire),
    .i_dat  (w_rd_dat),
    .i_perr (w_perr_raw),
    .o_vld  (rvalid),
    .o_dat  (rdata),
    .o_perr (perr)
  );

  assign busy = r_busy;
  assign err  = r_err;

endmodule

// File: tb/tb_sram_param.sv
// Bench for sram_param: two instances (RD_LAT=1 and RD_LAT=2, DEPTH=16,
// ADDR_W=5) share one stimulus stream. The driver updates an array-based
// reference memory and queues expected read results / error pulses; a
// negedge monitor pops and compares them as the DUTs respond.
module tb_sram_param;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 5;
`ifdef SRAM_PARAM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wr, rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic [DW-1:0] rdata1, rdata2;
  logic          rvalid1, rvalid2, busy1, busy2, err1, err2, perr1, perr2;

  sram_param #(.DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(1), .ADDR_W(AW)) u_lat1 (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1),
    .err(err1), .perr(perr1));

  sram_param #(.DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(2), .ADDR_W(AW)) u_lat2 (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata2), .rvalid(rvalid2), .busy(busy2),
    .err(err2), .perr(perr2));

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
    int            issue;
  } rd_item_t;

  rd_item_t      rq1[$], rq2[$];
  int            eq1[$], eq2[$];
  int            n_cmp = 0, n_bad = 0;
  int            cyc = 0;
  int            rst_edge = -1000;
  bit            started = 1'b0;
  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_bad [DEPTH];
  logic [DW-1:0] hold1 = '0, hold2 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    bit exp_busy;
    @(posedge clk); #1;
    if (started) begin
      exp_busy = (cyc - rst_edge) < DEPTH;
      n_cmp += 2;
      if (busy1 !== exp_busy) begin
        n_bad++;
        $display("FAIL busy_L1 cyc=%0d got=%b exp=%b", cyc, busy1, exp_busy);
      end
      if (busy2 !== exp_busy) begin
        n_bad++;
        $display("FAIL busy_L2 cyc=%0d got=%b exp=%b", cyc, busy2, exp_busy);
      end
    end
  endtask

  task automatic do_reset();
    int e;
    e = cyc + 1;
    rst = 1'b1; wr = 1'b0; rd = 1'b0;
    for (int i = rq1.size() - 1; i >= 0; i--) if (rq1[i].issue + 1 >= e) rq1.delete(i);
    for (int i = rq2.size() - 1; i >= 0; i--) if (rq2[i].issue + 2 >= e) rq2.delete(i);
    for (int i = eq1.size() - 1; i >= 0; i--) if (eq1[i] >= e) eq1.delete(i);
    for (int i = eq2.size() - 1; i >= 0; i--) if (eq2[i] >= e) eq2.delete(i);
    for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; ref_bad[i] = 1'b0; end
    rst_edge = e;
    started  = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Request presented now is sampled at edge cyc+1.
  task automatic issue(input logic w, input logic r, input int a,
                       input logic [DW-1:0] d, input logic [3:0] s);
    int k;
    rd_item_t it;
    k = cyc;
    wr = w; rd = r; addr = a[AW-1:0]; wdata = d; wstrb = s;
    if (w || r) begin
      if ((k + 1 - rst_edge) <= DEPTH || (w && r) || a >= DEPTH) begin
        eq1.push_back(k + 1);
        eq2.push_back(k + 1);
      end else if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        if (s[0]) ref_bad[a] = 1'b0;
      end else begin
        it.data  = ref_mem[a];
        it.perr  = PAR_EN && ref_bad[a];
        it.issue = k;
        rq1.push_back(it);
        rq2.push_back(it);
      end
    end
    tick();
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 0, '0, 4'h0);
  endtask

  task automatic mon(input int id, input logic v, input logic [DW-1:0] d,
                     input logic pe, input logic e);
    rd_item_t it;
    bit exp_v, exp_e;
    logic [DW-1:0] hold;
    exp_v = 1'b0; exp_e = 1'b0;
    if (id == 1) begin
      if (rq1.size() > 0 && rq1[0].issue + 1 == cyc) begin it = rq1.pop_front(); exp_v = 1'b1; end
      if (eq1.size() > 0 && eq1[0] == cyc) begin void'(eq1.pop_front()); exp_e = 1'b1; end
      hold = hold1;
    end else begin
      if (rq2.size() > 0 && rq2[0].issue + 2 == cyc) begin it = rq2.pop_front(); exp_v = 1'b1; end
      if (eq2.size() > 0 && eq2[0] == cyc) begin void'(eq2.pop_front()); exp_e = 1'b1; end
      hold = hold2;
    end
    if (cyc == rst_edge) hold = '0;
    n_cmp += 2;
    if (v !== exp_v) begin
      n_bad++;
      $display("FAIL rvalid_L%0d cyc=%0d got=%b exp=%b", id, cyc, v, exp_v);
    end
    if (e !== exp_e) begin
      n_bad++;
      $display("FAIL err_L%0d cyc=%0d got=%b exp=%b", id, cyc, e, exp_e);
    end
    if (exp_v) begin
      n_cmp += 2;
      if (d !== it.data) begin
        n_bad++;
        $display("FAIL rdata_L%0d cyc=%0d got=%h exp=%h", id, cyc, d, it.data);
      end
      if (pe !== it.perr) begin
        n_bad++;
        $display("FAIL perr_L%0d cyc=%0d got=%b exp=%b", id, cyc, pe, it.perr);
      end
      hold = it.data;
    end else if (v === 1'b1) begin
      hold = d;
    end else begin
      n_cmp += 2;
      if (d !== hold) begin
        n_bad++;
        $display("FAIL rdata_hold_L%0d cyc=%0d got=%h exp=%h", id, cyc, d, hold);
      end
      if (pe !== 1'b0) begin
        n_bad++;
        $display("FAIL perr_idle_L%0d cyc=%0d got=%b exp=0", id, cyc, pe);
      end
    end
    if (id == 1) hold1 = hold; else hold2 = hold;
  endtask

  always @(negedge clk) begin
    if (started) begin
      mon(1, rvalid1, rdata1, perr1, err1);
      mon(2, rvalid2, rdata2, perr2, err2);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    do_reset();
    repeat (DEPTH + 2) idle();
    for (int a = 0; a < DEPTH; a++) issue(1'b0, 1'b1, a, '0, 4'h0);
    repeat (3) idle();

    issue(1'b1, 1'b0, 3, 32'hDEADBEEF, 4'hF);
    issue(1'b1, 1'b0, 3, 32'h11223344, 4'b0101);
    issue(1'b0, 1'b1, 3, '0, 4'h0);
    repeat (3) idle();

    issue(1'b1, 1'b0, 5, 32'h55AA55AA, 4'hF);
    issue(1'b1, 1'b1, 5, 32'hFFFFFFFF, 4'hF);
    issue(1'b0, 1'b1, 20, '0, 4'h0);
    issue(1'b1, 1'b0, 20, 32'h12345678, 4'hF);
    issue(1'b1, 1'b0, 5, 32'h0BADF00D, 4'h0);
    issue(1'b0, 1'b1, 5, '0, 4'h0);
    repeat (3) idle();

    for (int a = 0; a < 4; a++) issue(1'b1, 1'b0, a, 32'hA0 + a, 4'hF);
    for (int a = 0; a < 4; a++) issue(1'b0, 1'b1, a, '0, 4'h0);
    repeat (3) idle();

    issue(1'b0, 1'b1, 1, '0, 4'h0);
    do_reset();
    repeat (7) idle();
    do_reset();
    issue(1'b0, 1'b1, 4, '0, 4'h0);
    repeat (DEPTH + 2) idle();
    issue(1'b0, 1'b1, 4, '0, 4'h0);
    repeat (3) idle();

`ifdef SRAM_PARAM_PARITY_EN
    issue(1'b1, 1'b0, 2, 32'h0F0F1234, 4'hF);
    idle();
    u_lat1.r_mem[2][0] = ~u_lat1.r_mem[2][0];
    u_lat2.r_mem[2][0] = ~u_lat2.r_mem[2][0];
    ref_bad[2] = 1'b1;
    issue(1'b0, 1'b1, 2, '0, 4'h0);
    issue(1'b0, 1'b1, 3, '0, 4'h0);
    repeat (3) idle();
`endif

    for (int i = 0; i < 600; i++) begin
      int sel;
      int a;
      sel = $urandom_range(0, 99);
      a   = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 15);
      if (sel < 2)       do_reset();
      else if (sel < 10) issue(1'b1, 1'b1, a, $urandom, 4'($urandom_range(0, 15)));
      else if (sel < 50) issue(1'b1, 1'b0, a, $urandom, 4'($urandom_range(0, 15)));
      else if (sel < 85) issue(1'b0, 1'b1, a, '0, 4'h0);
      else               idle();
    end
    repeat (5) idle();

    n_cmp += 4;
    if (rq1.size() != 0) begin n_bad++; $display("FAIL drain_rq_L1 got=%0d exp=0", rq1.size()); end
    if (rq2.size() != 0) begin n_bad++; $display("FAIL drain_rq_L2 got=%0d exp=0", rq2.size()); end
    if (eq1.size() != 0) begin n_bad++; $display("FAIL drain_err_L1 got=%0d exp=0", eq1.size()); end
    if (eq2.size() != 0) begin n_bad++; $display("FAIL drain_err_L2 got=%0d exp=0", eq2.size()); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
